// File: rtl/regfile_wr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr
// Purpose  : Write side of a 32 x 32-bit register file with byte-strobed
//            valid/ready writes and a sequenced 32-cycle bulk clear.
// Revision : 1.0
// ============================================================================
module regfile_wr #(
    parameter int ZERO_R0 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_valid,
    output logic        we_ready,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        wr_done,
    output logic [31:0] q0,
    output logic [31:0] q1,
    output logic [31:0] q2,
    output logic [31:0] q3,
    output logic [31:0] q4,
    output logic [31:0] q5,
    output logic [31:0] q6,
    output logic [31:0] q7,
    output logic [31:0] q8,
    output logic [31:0] q9,
    output logic [31:0] q10,
    output logic [31:0] q11,
    output logic [31:0] q12,
    output logic [31:0] q13,
    output logic [31:0] q14,
    output logic [31:0] q15,
    output logic [31:0] q16,
    output logic [31:0] q17,
    output logic [31:0] q18,
    output logic [31:0] q19,
    output logic [31:0] q20,
    output logic [31:0] q21,
    output logic [31:0] q22,
    output logic [31:0] q23,
    output logic [31:0] q24,
    output logic [31:0] q25,
    output logic [31:0] q26,
    output logic [31:0] q27,
    output logic [31:0] q28,
    output logic [31:0] q29,
    output logic [31:0] q30,
    output logic [31:0] q31
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_clr_cnt;
    logic        r_wr_done;
    logic [31:0] r_q [32];
    logic        w_accept;

    assign w_accept = we_valid && (r_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= w_accept;
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 5'd1;
                    if (r_clr_cnt == 5'd31) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A write accepted on the same edge that starts a clear still commits;
    // the clear sweep reaches that register later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                r_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 32; k++) begin
                if ((ZERO_R0 != 0) && (k == 0)) begin
                    r_q[k] <= '0;
                end else if ((r_state == CLEAR) && (r_clr_cnt == 5'(k))) begin
                    r_q[k] <= '0;
                end else if (w_accept && (waddr == 5'(k))) begin
                    for (int n = 0; n < 4; n++) begin
                        if (wstrb[n]) begin
                            r_q[k][8*n +: 8] <= wdata[8*n +: 8];
                        end
                    end
                end
            end
        end
    end

    assign we_ready = (r_state == IDLE);
    assign clr_busy = (r_state == CLEAR);
    assign wr_done  = r_wr_done;

    assign q0  = r_q[0];
    assign q1  = r_q[1];
    assign q2  = r_q[2];
    assign q3  = r_q[3];
    assign q4  = r_q[4];
    assign q5  = r_q[5];
    assign q6  = r_q[6];
    assign q7  = r_q[7];
    assign q8  = r_q[8];
    assign q9  = r_q[9];
    assign q10 = r_q[10];
    assign q11 = r_q[11];
    assign q12 = r_q[12];
    assign q13 = r_q[13];
    assign q14 = r_q[14];
    assign q15 = r_q[15];
    assign q16 = r_q[16];
    assign q17 = r_q[17];
    assign q18 = r_q[18];
    assign q19 = r_q[19];
    assign q20 = r_q[20];
    assign q21 = r_q[21];
    assign q22 = r_q[22];
    assign q23 = r_q[23];
    assign q24 = r_q[24];
    assign q25 = r_q[25];
    assign q26 = r_q[26];
    assign q27 = r_q[27];
    assign q28 = r_q[28];
    assign q29 = r_q[29];
    assign q30 = r_q[30];
    assign q31 = r_q[31];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr
// Purpose  : Self-checking bench for regfile_wr (ZERO_R0 = 1 and 0 instances).
// Revision : 1.0
// ============================================================================
module tb_regfile_wr;

    logic        clk;
    logic        rst;
    logic        we_valid;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        clr_req;
    logic        rdy_a, busy_a, done_a;
    logic        rdy_b, busy_b, done_b;
    logic [31:0] qa [32];
    logic [31:0] qb [32];

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    regfile_wr #(.ZERO_R0(1)) u_dut_a (
        .clk(clk), .rst(rst), .we_valid(we_valid), .we_ready(rdy_a),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .clr_req(clr_req),
        .clr_busy(busy_a), .wr_done(done_a),
        .q0(qa[0]),   .q1(qa[1]),   .q2(qa[2]),   .q3(qa[3]),
        .q4(qa[4]),   .q5(qa[5]),   .q6(qa[6]),   .q7(qa[7]),
        .q8(qa[8]),   .q9(qa[9]),   .q10(qa[10]), .q11(qa[11]),
        .q12(qa[12]), .q13(qa[13]), .q14(qa[14]), .q15(qa[15]),
        .q16(qa[16]), .q17(qa[17]), .q18(qa[18]), .q19(qa[19]),
        .q20(qa[20]), .q21(qa[21]), .q22(qa[22]), .q23(qa[23]),
        .q24(qa[24]), .q25(qa[25]), .q26(qa[26]), .q27(qa[27]),
        .q28(qa[28]), .q29(qa[29]), .q30(qa[30]), .q31(qa[31])
    );

    regfile_wr #(.ZERO_R0(0)) u_dut_b (
        .clk(clk), .rst(rst), .we_valid(we_valid), .we_ready(rdy_b),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .clr_req(clr_req),
        .clr_busy(busy_b), .wr_done(done_b),
        .q0(qb[0]),   .q1(qb[1]),   .q2(qb[2]),   .q3(qb[3]),
        .q4(qb[4]),   .q5(qb[5]),   .q6(qb[6]),   .q7(qb[7]),
        .q8(qb[8]),   .q9(qb[9]),   .q10(qb[10]), .q11(qb[11]),
        .q12(qb[12]), .q13(qb[13]), .q14(qb[14]), .q15(qb[15]),
        .q16(qb[16]), .q17(qb[17]), .q18(qb[18]), .q19(qb[19]),
        .q20(qb[20]), .q21(qb[21]), .q22(qb[22]), .q23(qb[23]),
        .q24(qb[24]), .q25(qb[25]), .q26(qb[26]), .q27(qb[27]),
        .q28(qb[28]), .q29(qb[29]), .q30(qb[30]), .q31(qb[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents plus number of clear steps still to run.
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    int          m_left;
    bit          m_done;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = d[8*n +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) begin ma[k] = '0; mb[k] = '0; end
            m_left = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                ma[32 - m_left] = '0;
                mb[32 - m_left] = '0;
                m_left = m_left - 1;
            end else begin
                if (we_valid) begin
                    if (waddr != 5'd0) ma[waddr] = merge(ma[waddr], wdata, wstrb);
                    mb[waddr] = merge(mb[waddr], wdata, wstrb);
                    m_done = 1;
                end
                if (clr_req) m_left = 32;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            for (int k = 0; k < 32; k++) begin
                chk($sformatf("model_qa[%0d]", k), qa[k], ma[k]);
                chk($sformatf("model_qb[%0d]", k), qb[k], mb[k]);
            end
            chk("model_we_ready_a", 32'(rdy_a), 32'(m_left == 0));
            chk("model_we_ready_b", 32'(rdy_b), 32'(m_left == 0));
            chk("model_clr_busy_a", 32'(busy_a), 32'(m_left > 0));
            chk("model_clr_busy_b", 32'(busy_b), 32'(m_left > 0));
            chk("model_wr_done_a", 32'(done_a), 32'(m_done));
            chk("model_wr_done_b", 32'(done_b), 32'(m_done));
        end
    end

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        we_valid = 1'b1; waddr = a; wdata = d; wstrb = s;
        @(negedge clk);
        we_valid = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base);
        @(negedge clk);
        we_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            waddr = 5'(k); wdata = base + 32'(k); wstrb = 4'hF;
            @(negedge clk);
        end
        we_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy_a; i++) @(negedge clk);
        chk("clear_timeout", 32'(busy_a), 32'd0);
    endtask

    int busy_cnt, lowrdy_cnt, nz;

    initial begin
        rst = 1'b1; we_valid = 1'b0; waddr = '0; wdata = '0; wstrb = '0; clr_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_en = 1;
        @(negedge clk);
        chk("reset_q5", qa[5], 32'h0);
        chk("reset_we_ready", 32'(rdy_a), 32'd1);
        chk("reset_clr_busy", 32'(busy_a), 32'd0);
        chk("reset_wr_done", 32'(done_a), 32'd0);

        do_write(5'd5, 32'hDEADBEEF, 4'hF);
        chk("full_write_q5", qa[5], 32'hDEADBEEF);
        chk("full_write_done", 32'(done_a), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_a), 32'd0);

        do_write(5'd5, 32'h11223344, 4'b0101);
        chk("strobe_merge_q5", qa[5], 32'hDE22BE44);

        do_write(5'd0, 32'hFFFFFFFF, 4'hF);
        chk("r0_zero_locked", qa[0], 32'h0);
        chk("r0_writable", qb[0], 32'hFFFFFFFF);
        chk("r0_write_done", 32'(done_a), 32'd1);

        do_write(5'd7, 32'hFFFFFFFF, 4'h0);
        chk("no_strobe_q7", qa[7], 32'h0);
        chk("no_strobe_done", 32'(done_a), 32'd1);

        // Back-to-back writes to the same register
        @(negedge clk);
        we_valid = 1'b1; waddr = 5'd9; wdata = 32'hAABBCCDD; wstrb = 4'hF;
        @(negedge clk);
        wdata = 32'h00000011; wstrb = 4'b0001;
        @(negedge clk);
        we_valid = 1'b0;
        chk("b2b_merge_q9", qa[9], 32'hAABBCC11);

        // Fill with index, pulse a clear, hold a write through it
        fill(32'h0);
        chk("fill_q31", qa[31], 32'd31);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        we_valid = 1'b1; waddr = 5'd12; wdata = 32'h12345678; wstrb = 4'hF;
        busy_cnt = 0; lowrdy_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            if (busy_a) busy_cnt++;
            if (!rdy_a) lowrdy_cnt++;
            if (j == 11) begin
                chk("clear_progress_q10", qa[10], 32'h0);
                chk("clear_progress_q11", qa[11], 32'd11);
            end
            if (j == 33) chk("held_write_accepted", qa[12], 32'h12345678);
            @(negedge clk);
        end
        we_valid = 1'b0;
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("we_ready_low_cycles", 32'(lowrdy_cnt), 32'd32);
        chk("after_clear_q31", qa[31], 32'h0);

        // Write and clear requested together
        @(negedge clk);
        we_valid = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5; wstrb = 4'hF; clr_req = 1'b1;
        @(negedge clk);
        we_valid = 1'b0; clr_req = 1'b0;
        chk("simul_done", 32'(done_a), 32'd1);
        chk("simul_q3", qa[3], 32'hA5A5A5A5);
        repeat (3) @(negedge clk);
        chk("simul_q3_before", qa[3], 32'hA5A5A5A5);
        @(negedge clk);
        chk("simul_q3_cleared", qa[3], 32'h0);
        wait_idle();

        // Asynchronous reset in the middle of a clear
        fill(32'hF0);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_q20", qa[20], 32'h104);
        chk("pre_reset_busy", 32'(busy_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        nz = 0;
        for (int k = 0; k < 32; k++) begin
            if (qa[k] != 32'h0) nz++;
            if (qb[k] != 32'h0) nz++;
        end
        chk("async_reset_q_nonzero", 32'(nz), 32'd0);
        chk("async_reset_busy", 32'(busy_a), 32'd0);
        chk("async_reset_done", 32'(done_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", 32'(rdy_a), 32'd1);
        do_write(5'd4, 32'hCAFEF00D, 4'hF);
        chk("post_reset_write", qa[4], 32'hCAFEF00D);
        @(negedge clk);

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
